// File: rtl/dbg_bus_master_pkg.sv
// dbg_bus_master shared definitions
// opcodes, reply codes and FSM states
package dbg_bus_master_pkg;

   localparam logic [7:0] OP_WR   = 8'h57;
   localparam logic [7:0] OP_RD   = 8'h52;
   localparam logic [7:0] RSP_ACK = 8'h4B;
   localparam logic [7:0] RSP_BAD = 8'h3F;
   localparam logic [7:0] RSP_ALN = 8'h41;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_REQ,
      ST_RESP
   } state_e;

endpackage

// File: rtl/dbg_bus_master.sv
// Debug bus initiator: UART byte commands
// to single-word bus reads and writes
module dbg_bus_master
   import dbg_bus_master_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        sys_rstn,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        bus_req,
   input  logic        bus_gnt,
   output logic [31:0] Addr,
   output logic [31:0] WD,
   output logic        WE,
   input  logic [31:0] RD,
   output logic        busy,
   output logic        err_overrun
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_e        state;
   logic          is_wr;
   logic [1:0]    byte_cnt;
   logic [TW-1:0] to_cnt;
   logic [31:0]   addr_sr;
   logic [31:0]   data_sr;
   logic [31:0]   resp_sr;
   logic [1:0]    resp_left;

   logic [31:0]   addr_nx;
   logic [31:0]   data_nx;
   logic          last_byte;

   // incoming byte shifted into whichever field is being collected
   assign addr_nx = (state == ST_ADDR) ? {addr_sr[23:0], rx_data} : addr_sr;
   assign data_nx = (state == ST_DATA) ? {data_sr[23:0], rx_data} : data_sr;
   assign last_byte = (byte_cnt == 2'd3) &&
                      ((state == ST_DATA) ||
                       ((state == ST_ADDR) && !is_wr));

   // write strobe only exists in the granted access cycle
   assign WE   = bus_req & bus_gnt & is_wr;
   assign busy = (state != ST_IDLE);

   // command parser, bus request and response sequencer
   always_ff @(posedge clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         state     <= ST_IDLE;
         is_wr     <= 1'b0;
         byte_cnt  <= 2'd0;
         to_cnt    <= '0;
         addr_sr   <= 32'd0;
         data_sr   <= 32'd0;
         resp_sr   <= 32'd0;
         resp_left <= 2'd0;
         tx_data   <= 8'd0;
         tx_valid  <= 1'b0;
         bus_req   <= 1'b0;
         Addr      <= 32'd0;
         WD        <= 32'd0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (rx_valid) begin
                  is_wr    <= (rx_data == OP_WR);
                  byte_cnt <= 2'd0;
                  to_cnt   <= '0;
                  if (rx_data == OP_WR || rx_data == OP_RD) begin
                     state <= ST_ADDR;
                  end else begin
                     tx_data   <= RSP_BAD;
                     tx_valid  <= 1'b1;
                     resp_left <= 2'd0;
                     state     <= ST_RESP;
                  end
               end
            end
            ST_ADDR, ST_DATA: begin
               if (rx_valid) begin
                  to_cnt   <= '0;
                  byte_cnt <= byte_cnt + 2'd1;
                  addr_sr  <= addr_nx;
                  data_sr  <= data_nx;
                  if (last_byte) begin
                     if (addr_nx[1:0] != 2'b00) begin
                        tx_data   <= RSP_ALN;
                        tx_valid  <= 1'b1;
                        resp_left <= 2'd0;
                        state     <= ST_RESP;
                     end else begin
                        Addr    <= addr_nx;
                        if (is_wr) WD <= data_nx;
                        bus_req <= 1'b1;
                        state   <= ST_REQ;
                     end
                  end else if (state == ST_ADDR && byte_cnt == 2'd3) begin
                     state <= ST_DATA;
                  end
               end else if (to_cnt == TO_LAST) begin
                  state <= ST_IDLE;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            ST_REQ: begin
               if (bus_gnt) begin
                  bus_req  <= 1'b0;
                  tx_valid <= 1'b1;
                  state    <= ST_RESP;
                  if (is_wr) begin
                     tx_data   <= RSP_ACK;
                     resp_left <= 2'd0;
                  end else begin
                     tx_data   <= RD[31:24];
                     resp_sr   <= {RD[23:0], 8'd0};
                     resp_left <= 2'd3;
                  end
               end
            end
            ST_RESP: begin
               if (tx_ready) begin
                  if (resp_left != 2'd0) begin
                     tx_data   <= resp_sr[31:24];
                     resp_sr   <= {resp_sr[23:0], 8'd0};
                     resp_left <= resp_left - 2'd1;
                  end else begin
                     tx_valid <= 1'b0;
                     state    <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // sticky flag for bytes that arrive while a command is in flight
   always_ff @(posedge clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         err_overrun <= 1'b0;
      end else if (rx_valid && (state == ST_REQ || state == ST_RESP)) begin
         err_overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dbg_bus_master.sv
// Directed testbench for dbg_bus_master
// short timeout so abort paths run quickly
module tb_dbg_bus_master;

   logic        clk = 1'b0;
   logic        sys_rstn;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        bus_req;
   logic        bus_gnt;
   logic [31:0] Addr;
   logic [31:0] WD;
   logic        WE;
   logic [31:0] RD;
   logic        busy;
   logic        err_overrun;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  txq[$];
   int          we_cnt = 0;
   logic [31:0] we_addr;
   logic [31:0] we_wd;
   bit          req_seen = 0;
   bit          we_nognt = 0;

   dbg_bus_master #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk),
      .sys_rstn(sys_rstn),
      .rx_valid(rx_valid),
      .rx_data(rx_data),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .bus_req(bus_req),
      .bus_gnt(bus_gnt),
      .Addr(Addr),
      .WD(WD),
      .WE(WE),
      .RD(RD),
      .busy(busy),
      .err_overrun(err_overrun)
   );

   always #5 clk = ~clk;

   // observe the DUT mid-cycle, inputs only change just after posedge
   always @(negedge clk) begin
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      if (WE) begin
         we_cnt++;
         we_addr = Addr;
         we_wd   = WD;
         if (!bus_gnt) we_nognt = 1;
      end
      if (bus_req) req_seen = 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick(1);
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (busy && k < 200) begin
         tick(1);
         k++;
      end
      n_cmp++;
      if (busy) begin
         n_bad++;
         $display("FAIL %s: still busy after %0d cycles, required idle", name, k);
      end
      tick(1);
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({busy, tx_valid, bus_req, WE, err_overrun} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_flags: got %b required 00000",
                  {busy, tx_valid, bus_req, WE, err_overrun});
      end
      n_cmp++;
      if ({Addr, WD, tx_data} !== 72'd0) begin
         n_bad++;
         $display("FAIL reset_regs: Addr=%h WD=%h tx=%h required 0",
                  Addr, WD, tx_data);
      end
   endtask

   task automatic test_write();
      logic [7:0] cmd[9] = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h10,
                             8'hDE, 8'hAD, 8'hBE, 8'hEF};
      txq.delete();
      we_cnt = 0;
      bus_gnt = 1'b1;
      tx_ready = 1'b1;
      foreach (cmd[i]) send_byte(cmd[i]);
      n_cmp++;
      if (bus_req !== 1'b1 || WE !== 1'b1) begin
         n_bad++;
         $display("FAIL wr_req: bus_req=%b WE=%b required 1 1", bus_req, WE);
      end
      wait_idle("wr_idle");
      n_cmp++;
      if (we_cnt != 1 || we_addr !== 32'h10 || we_wd !== 32'hDEADBEEF) begin
         n_bad++;
         $display("FAIL wr_bus: we_cnt=%0d A=%h D=%h required 1 00000010 deadbeef",
                  we_cnt, we_addr, we_wd);
      end
      n_cmp++;
      if (txq.size() != 1 || txq[0] !== 8'h4B) begin
         n_bad++;
         $display("FAIL wr_reply: n=%0d b0=%h required 1 4b", txq.size(),
                  txq.size() > 0 ? txq[0] : 8'hxx);
      end
   endtask

   task automatic test_read();
      logic [7:0] cmd[5] = '{8'h52, 8'h00, 8'h00, 8'h7F, 8'h00};
      logic [7:0] exp[4] = '{8'h12, 8'h34, 8'h56, 8'h78};
      bit ok;
      txq.delete();
      we_cnt = 0;
      RD = 32'h12345678;
      foreach (cmd[i]) send_byte(cmd[i]);
      tick(5);
      n_cmp++;
      if (busy !== 1'b0 || tx_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rd_turnaround: busy=%b tx_valid=%b required 0 0 at N+5",
                  busy, tx_valid);
      end
      ok = (txq.size() == 4);
      if (ok) foreach (exp[i]) if (txq[i] !== exp[i]) ok = 0;
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL rd_reply: got %p required 12 34 56 78", txq);
      end
      n_cmp++;
      if (we_cnt != 0 || Addr !== 32'h00007F00) begin
         n_bad++;
         $display("FAIL rd_bus: we_cnt=%0d Addr=%h required 0 00007f00",
                  we_cnt, Addr);
      end
   endtask

   task automatic test_grant_delay();
      logic [7:0] cmd[9] = '{8'h57, 8'h00, 8'h00, 8'h01, 8'h00,
                             8'h11, 8'h22, 8'h33, 8'h44};
      int bad;
      txq.delete();
      we_cnt = 0;
      we_nognt = 0;
      bus_gnt = 1'b0;
      foreach (cmd[i]) send_byte(cmd[i]);
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus_req !== 1'b1 || WE !== 1'b0 || Addr !== 32'h100) bad++;
         tick(1);
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL gnt_hold: %0d bad cycles, required 0", bad);
      end
      bus_gnt = 1'b1;
      #1;
      n_cmp++;
      if (WE !== 1'b1 || WD !== 32'h11223344) begin
         n_bad++;
         $display("FAIL gnt_access: WE=%b WD=%h required 1 11223344", WE, WD);
      end
      tick(1);
      bus_gnt = 1'b0;
      wait_idle("gnt_idle");
      n_cmp++;
      if (we_cnt != 1 || we_nognt || txq.size() != 1) begin
         n_bad++;
         $display("FAIL gnt_single: we_cnt=%0d nognt=%b replies=%0d required 1 0 1",
                  we_cnt, we_nognt, txq.size());
      end
      bus_gnt = 1'b1;
   endtask

   task automatic test_errors();
      logic [7:0] cmd[5] = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h02};
      txq.delete();
      send_byte(8'h00);
      wait_idle("bad_idle");
      n_cmp++;
      if (txq.size() != 1 || txq[0] !== 8'h3F) begin
         n_bad++;
         $display("FAIL bad_opcode: got %p required 3f", txq);
      end
      txq.delete();
      req_seen = 0;
      foreach (cmd[i]) send_byte(cmd[i]);
      wait_idle("aln_idle");
      n_cmp++;
      if (txq.size() != 1 || txq[0] !== 8'h41 || req_seen) begin
         n_bad++;
         $display("FAIL misaligned: got %p req_seen=%b required 41 0",
                  txq, req_seen);
      end
   endtask

   task automatic test_timeout();
      logic [7:0] cmd[5] = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h00};
      logic [7:0] exp[4] = '{8'hA5, 8'hA5, 8'h0F, 8'h0F};
      bit ok;
      txq.delete();
      send_byte(8'h57);
      send_byte(8'h00);
      tick(15);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL to_early: busy=%b after 15 idle cycles, required 1", busy);
      end
      tick(1);
      n_cmp++;
      if (busy !== 1'b0 || txq.size() != 0) begin
         n_bad++;
         $display("FAIL to_abort: busy=%b replies=%0d required 0 0",
                  busy, txq.size());
      end
      RD = 32'hA5A50F0F;
      foreach (cmd[i]) send_byte(cmd[i]);
      wait_idle("to_next_idle");
      ok = (txq.size() == 4);
      if (ok) foreach (exp[i]) if (txq[i] !== exp[i]) ok = 0;
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL to_next: got %p required a5 a5 0f 0f", txq);
      end
   endtask

   task automatic test_overrun();
      logic [7:0] cmd[5] = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h04};
      logic [7:0] exp[4] = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
      bit ok;
      int bad;
      txq.delete();
      we_cnt = 0;
      RD = 32'hCAFEF00D;
      tx_ready = 1'b0;
      foreach (cmd[i]) send_byte(cmd[i]);
      tick(1);
      send_byte(8'h57);
      bad = 0;
      for (int c = 0; c < 8; c++) begin
         if (tx_valid !== 1'b1 || tx_data !== 8'hCA) bad++;
         tick(1);
      end
      n_cmp++;
      if (bad != 0 || err_overrun !== 1'b1) begin
         n_bad++;
         $display("FAIL ovr_hold: bad=%0d err_overrun=%b required 0 1",
                  bad, err_overrun);
      end
      tx_ready = 1'b1;
      wait_idle("ovr_idle");
      ok = (txq.size() == 4);
      if (ok) foreach (exp[i]) if (txq[i] !== exp[i]) ok = 0;
      n_cmp++;
      if (!ok || we_cnt != 0) begin
         n_bad++;
         $display("FAIL ovr_reply: got %p we=%0d required ca fe f0 0d, 0",
                  txq, we_cnt);
      end
      tick(3);
      n_cmp++;
      if (err_overrun !== 1'b1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL ovr_sticky: err=%b busy=%b required 1 0",
                  err_overrun, busy);
      end
      sys_rstn = 1'b0;
      #2;
      n_cmp++;
      if (err_overrun !== 1'b0) begin
         n_bad++;
         $display("FAIL ovr_clear: err_overrun=%b required 0", err_overrun);
      end
      tick(2);
      sys_rstn = 1'b1;
   endtask

   initial begin
      sys_rstn = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'd0;
      tx_ready = 1'b1;
      bus_gnt  = 1'b1;
      RD       = 32'd0;
      tick(3);
      test_reset();
      sys_rstn = 1'b1;
      tick(2);
      test_write();
      test_read();
      test_grant_delay();
      test_errors();
      test_timeout();
      test_overrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
